// File: rtl/ccu_pkg.sv
// ============================================================================
// Module      : ccu_pkg
// Description : Shared constants, FSM state type and helper for the command
//               issuer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ccu_pkg;

    localparam int               CMD_W       = 8;
    localparam logic [CMD_W-1:0] CMD_NOP     = 8'h00;
    localparam logic [1:0]       WAIT_PREFIX = 2'b11;
    localparam int               WAIT_CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } issuer_state_t;

    // A byte whose top two bits match WAIT_PREFIX is a delay directive.
    function automatic logic is_wait(input logic [CMD_W-1:0] c);
        return c[CMD_W-1 -: 2] == WAIT_PREFIX;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ccu_cmd_fifo.sv
// ============================================================================
// Module      : ccu_cmd_fifo
// Description : Power-of-two command FIFO with first-word fall-through output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccu_cmd_fifo
    import ccu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [CMD_W-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CMD_W-1:0] dout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == C_DEPTH);
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ccu_cmd_issuer.sv
// ============================================================================
// Module      : ccu_cmd_issuer
// Description : Buffers host command bytes and issues them to the CCU, turning
//               WAIT directives into idle cycles. Optional statistics counter
//               enabled by macro ISSUER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccu_cmd_issuer
    import ccu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CMD_W-1:0] host_cmd,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic             stall,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_valid
`ifdef ISSUER_STATS_EN
    ,
    output logic [15:0]      issued_cnt
`endif
);

    issuer_state_t         state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CMD_W-1:0]      cmd_q, cmd_d;
    logic                  cmd_valid_q, cmd_valid_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [CMD_W-1:0]      fifo_dout;

    // Ready comes from the pre-edge full flag, so a pop never frees a slot
    // for a push in the same cycle.
    assign host_ready = !fifo_full && !rst;

    ccu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (host_valid && host_ready),
        .din   (host_cmd),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        fifo_pop    = 1'b0;
        if (!stall) begin
            case (state_q)
                IDLE: begin
                    cmd_d       = CMD_NOP;
                    cmd_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    cmd_d       = CMD_NOP;
                    cmd_valid_d = 1'b0;
                    if (fifo_empty) begin
                        state_d = IDLE;
                    end else begin
                        fifo_pop = 1'b1;
                        if (is_wait(fifo_dout)) begin
                            wait_cnt_d = fifo_dout[WAIT_CNT_W-1:0];
                            if (fifo_dout[WAIT_CNT_W-1:0] != '0) begin
                                state_d = WAIT;
                            end
                        end else begin
                            cmd_d       = fifo_dout;
                            cmd_valid_d = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    cmd_d       = CMD_NOP;
                    cmd_valid_d = 1'b0;
                    wait_cnt_d  = wait_cnt_q - 1'b1;
                    if (wait_cnt_q == WAIT_CNT_W'(1)) begin
                        state_d = ISSUE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    cmd_d       = CMD_NOP;
                    cmd_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            cmd_q       <= CMD_NOP;
            cmd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;

`ifdef ISSUER_STATS_EN
    logic [15:0] issued_cnt_q, issued_cnt_d;
    logic        issue_fire;

    assign issue_fire = fifo_pop && !is_wait(fifo_dout);

    always_comb begin
        issued_cnt_d = issued_cnt_q;
        if (issue_fire && (issued_cnt_q != 16'hFFFF)) begin
            issued_cnt_d = issued_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt_q <= '0;
        end else begin
            issued_cnt_q <= issued_cnt_d;
        end
    end

    assign issued_cnt = issued_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ccu_cmd_issuer.sv
// ============================================================================
// Module      : tb_ccu_cmd_issuer
// Description : Self-checking bench for ccu_cmd_issuer (DEPTH=4); covers the
//               issued_cnt port when ISSUER_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ccu_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  host_cmd;
    logic        host_valid;
    wire logic   host_ready;
    logic        stall;
    wire logic [7:0] cmd;
    wire logic   cmd_valid;
`ifdef ISSUER_STATS_EN
    wire logic [15:0] issued_cnt;
`endif

    ccu_cmd_issuer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .host_cmd   (host_cmd),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .stall      (stall),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid)
`ifdef ISSUER_STATS_EN
        ,
        .issued_cnt (issued_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_issued = 0;

    logic [7:0] pq[$];
    logic [8:0] got_tr [32];
    logic [8:0] exp_tr [32];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer the bytes in pq on consecutive edges 0..; sample after each edge.
    task automatic drive_trace(input int stall_from, input int stall_len, input int n);
        for (int j = 0; j < n; j++) begin
            host_valid = (j < pq.size());
            host_cmd   = (j < pq.size()) ? pq[j] : 8'h00;
            stall      = (j >= stall_from) && (j < stall_from + stall_len);
            tick();
            got_tr[j] = {cmd_valid, cmd};
        end
        host_valid = 1'b0;
        host_cmd   = 8'h00;
        stall      = 1'b0;
    endtask

    task automatic clear_exp();
        for (int j = 0; j < 32; j++) exp_tr[j] = 9'h000;
    endtask

    task automatic check_trace(input string tag, input int n);
        for (int j = 0; j < n; j++) chk(tag, 16'(got_tr[j]), 16'(exp_tr[j]));
    endtask

    // Command a, WAIT n, command b: a lands 2 edges after its push, then n+1 idle cycles.
    task automatic wait_trial(input logic [7:0] a, input int n, input logic [7:0] b);
        pq.delete();
        pq.push_back(a);
        pq.push_back({2'b11, 6'(n)});
        pq.push_back(b);
        drive_trace(99, 0, n + 7);
        clear_exp();
        exp_tr[2]     = {1'b1, a};
        exp_tr[n + 4] = {1'b1, b};
        check_trace("wait_seq", n + 7);
        exp_issued += 2;
    endtask

    initial begin
        logic [7:0] q_exp[$];
        logic [7:0] got_q[$];
        logic [7:0] full_bytes[5];
        logic [8:0] prev;
        logic       st;
        logic [7:0] b;

        rst = 1'b1; host_valid = 1'b0; host_cmd = 8'h00; stall = 1'b0;

        // Reset, then idle
        tick();
        chk("rst_ready", 16'(host_ready), 16'd0);
        tick();
        chk("rst_cmd", 16'(cmd), 16'h00);
        chk("rst_valid", 16'(cmd_valid), 16'd0);
        rst = 1'b0;
        tick();
        chk("idle_cmd", 16'(cmd), 16'h00);
        chk("idle_valid", 16'(cmd_valid), 16'd0);
        chk("idle_ready", 16'(host_ready), 16'd1);
`ifdef ISSUER_STATS_EN
        chk("rst_issued", issued_cnt, 16'd0);
`endif

        // Single command latency
        pq.delete(); pq.push_back(8'h4C);
        drive_trace(99, 0, 6);
        clear_exp(); exp_tr[2] = {1'b1, 8'h4C};
        check_trace("single", 6);
        exp_issued += 1;

        // WAIT directives: directed, zero-count, then random counts
        wait_trial(8'h4C, 3, 8'h4B);
        wait_trial(8'h12, 0, 8'h34);
        for (int t = 0; t < 4; t++)
            wait_trial(8'($urandom_range(0, 191)), $urandom_range(0, 10), 8'($urandom_range(0, 191)));

        // Stall while 8'h4B is on cmd
        pq.delete(); pq.push_back(8'h4C); pq.push_back(8'h4B); pq.push_back(8'h49);
        drive_trace(4, 3, 10);
        clear_exp();
        exp_tr[2] = {1'b1, 8'h4C};
        for (int j = 3; j <= 6; j++) exp_tr[j] = {1'b1, 8'h4B};
        exp_tr[7] = {1'b1, 8'h49};
        check_trace("stall_hold", 10);
        exp_issued += 3;

        // Full FIFO under stall; a push offered as the first pop happens is refused
        full_bytes[0] = 8'h11; full_bytes[1] = 8'h22; full_bytes[2] = 8'h33;
        full_bytes[3] = 8'h44; full_bytes[4] = 8'h55;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            host_cmd = full_bytes[i]; host_valid = 1'b1;
            chk("full_ready", 16'(host_ready), 16'(i < 4));
            tick();
        end
        host_valid = 1'b0;
        chk("full_ready_after", 16'(host_ready), 16'd0);
        chk("full_stalled_valid", 16'(cmd_valid), 16'd0);
        stall = 1'b0; host_valid = 1'b1; host_cmd = 8'h55;
        tick();
        chk("full_ready_edge1", 16'(host_ready), 16'd0);
        tick();
        host_valid = 1'b0;
        got_q.delete();
        if (cmd_valid) got_q.push_back(cmd);
        chk("full_ready_after_pop", 16'(host_ready), 16'd1);
        for (int j = 0; j < 10; j++) begin
            tick();
            if (cmd_valid) got_q.push_back(cmd);
        end
        chk("full_count", 16'(got_q.size()), 16'd4);
        for (int i = 0; i < 4; i++)
            chk("full_order", 16'((i < got_q.size()) ? got_q[i] : 8'hEE), 16'(full_bytes[i]));
        exp_issued += 4;

        // Random traffic against an ordered stream model
        q_exp.delete();
        prev = {cmd_valid, cmd};
        for (int c = 0; c < 400; c++) begin
            if (c < 300) begin
                host_valid = 1'($urandom_range(0, 1));
                b = ($urandom_range(0, 4) == 0) ? {2'b11, 6'($urandom_range(0, 4))}
                                                : 8'($urandom_range(0, 191));
                host_cmd = b;
                stall = ($urandom_range(0, 3) == 0);
            end else begin
                host_valid = 1'b0;
                stall = 1'b0;
            end
            st = stall;
            if (host_valid && host_ready && (host_cmd[7:6] != 2'b11))
                q_exp.push_back(host_cmd);
            tick();
            if (st) begin
                chk("rnd_hold", 16'({cmd_valid, cmd}), 16'(prev));
            end else if (cmd_valid) begin
                chk("rnd_cmd", 16'(cmd), (q_exp.size() > 0) ? 16'(q_exp.pop_front()) : 16'hFFFF);
                exp_issued++;
            end else begin
                chk("rnd_nop", 16'(cmd), 16'h00);
            end
            prev = {cmd_valid, cmd};
        end
        chk("rnd_drained", 16'(q_exp.size()), 16'd0);
`ifdef ISSUER_STATS_EN
        chk("issued_total", issued_cnt, 16'(exp_issued));
`endif

        // Reset in the middle of a long WAIT
        pq.delete(); pq.push_back(8'hFF);
        drive_trace(99, 0, 6);
        clear_exp();
        check_trace("rstw_pre", 6);
        rst = 1'b1;
        tick();
        chk("rstw_cmd", 16'(cmd), 16'h00);
        chk("rstw_valid", 16'(cmd_valid), 16'd0);
        chk("rstw_ready", 16'(host_ready), 16'd0);
`ifdef ISSUER_STATS_EN
        chk("rstw_issued0", issued_cnt, 16'd0);
`endif
        rst = 1'b0;
        #1;
        chk("rstw_ready_rel", 16'(host_ready), 16'd1);
        pq.delete(); pq.push_back(8'h40);
        drive_trace(99, 0, 8);
        clear_exp(); exp_tr[2] = {1'b1, 8'h40};
        check_trace("rstw_post", 8);
`ifdef ISSUER_STATS_EN
        chk("rstw_issued1", issued_cnt, 16'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
